// File: rtl/au4_acc_ctrl.sv
// Command-driven accumulator controller for the 4-bit arithmetic unit.
// The AU is external: this block drives its operands/selects and registers its result.
module au4_acc_ctrl #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [2:0]       cmd_op,
  input  logic [WIDTH-1:0] cmd_data,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] acc,
  output logic             flag_c,
  output logic             flag_z,
  output logic             flag_n,
  output logic             flag_v,
  output logic             au_s1,
  output logic             au_s0,
  output logic             au_cin,
  output logic [WIDTH-1:0] au_a,
  output logic [WIDTH-1:0] au_b,
  input  logic [WIDTH-1:0] au_g,
  input  logic             au_cout
);

  typedef enum logic [2:0] {IDLE, EXEC, MUL_INIT, MUL_RUN, RESP} state_t;

  localparam logic [2:0] OP_LOAD = 3'd0;
  localparam logic [2:0] OP_ADD  = 3'd1;
  localparam logic [2:0] OP_ADC  = 3'd2;
  localparam logic [2:0] OP_SUB  = 3'd3;
  localparam logic [2:0] OP_SBB  = 3'd4;
  localparam logic [2:0] OP_INC  = 3'd5;
  localparam logic [2:0] OP_DEC  = 3'd6;
  localparam logic [2:0] OP_MUL  = 3'd7;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic             flag_c_q, flag_c_d, flag_z_q, flag_z_d;
  logic             flag_n_q, flag_n_d, flag_v_q, flag_v_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic             cmd_ready_q, cmd_ready_d;
  logic [2:0]       op_q, op_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic [WIDTH-1:0] prod_q, prod_d;
  logic [WIDTH-1:0] mcand_q, mcand_d;
  logic             ovf_q, ovf_d;

  logic [WIDTH-1:0] au_y;
  logic             au_v;

  // AU drive; the idle pattern (S=00, cin=0, A=acc, B=0) applies outside EXEC and active MUL_RUN.
  always_comb begin
    au_s1  = 1'b0;
    au_s0  = 1'b0;
    au_cin = 1'b0;
    au_a   = acc_q;
    au_b   = '0;
    case (state_q)
      EXEC: begin
        au_b = data_q;
        case (op_q)
          OP_ADD: au_s0 = 1'b1;
          OP_ADC: begin au_s0 = 1'b1; au_cin = flag_c_q; end
          OP_SUB: begin au_s1 = 1'b1; au_cin = 1'b1; end
          OP_SBB: begin au_s1 = 1'b1; au_cin = flag_c_q; end
          OP_INC: au_cin = 1'b1;
          OP_DEC: begin au_s1 = 1'b1; au_s0 = 1'b1; end
          default: ;
        endcase
      end
      MUL_RUN: begin
        if (count_q != '0) begin
          au_a  = prod_q;
          au_b  = mcand_q;
          au_s0 = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // Second AU operand as the adder actually sees it, needed for signed overflow.
  always_comb begin
    case ({au_s1, au_s0})
      2'b00:   au_y = '0;
      2'b01:   au_y = au_b;
      2'b10:   au_y = ~au_b;
      default: au_y = '1;
    endcase
    au_v = (au_a[WIDTH-1] == au_y[WIDTH-1]) && (au_g[WIDTH-1] != au_a[WIDTH-1]);
  end

  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    flag_c_d = flag_c_q;
    flag_z_d = flag_z_q;
    flag_n_d = flag_n_q;
    flag_v_d = flag_v_q;
    op_d     = op_q;
    data_d   = data_q;
    count_d  = count_q;
    prod_d   = prod_q;
    mcand_d  = mcand_q;
    ovf_d    = ovf_q;
    case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          op_d    = cmd_op;
          data_d  = cmd_data;
          state_d = (cmd_op == OP_MUL) ? MUL_INIT : EXEC;
        end
      end
      EXEC: begin
        if (op_q == OP_LOAD) begin
          acc_d    = data_q;
          flag_c_d = 1'b0;
          flag_v_d = 1'b0;
        end else begin
          acc_d    = au_g;
          flag_c_d = au_cout;
          flag_v_d = au_v;
        end
        flag_z_d = (acc_d == '0);
        flag_n_d = acc_d[WIDTH-1];
        state_d  = RESP;
      end
      MUL_INIT: begin
        prod_d  = '0;
        count_d = data_q;
        mcand_d = acc_q;
        ovf_d   = 1'b0;
        state_d = MUL_RUN;
      end
      MUL_RUN: begin
        if (count_q != '0) begin
          prod_d  = au_g;
          ovf_d   = ovf_q | au_cout;
          count_d = count_q - WIDTH'(1);
        end else begin
          acc_d    = prod_q;
          flag_c_d = ovf_q;
          flag_v_d = 1'b0;
          flag_z_d = (prod_q == '0);
          flag_n_d = prod_q[WIDTH-1];
          state_d  = RESP;
        end
      end
      RESP: begin
        if (rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    cmd_ready_d = (state_d == IDLE);
    rsp_valid_d = (state_d == RESP);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      acc_q       <= '0;
      flag_c_q    <= 1'b0;
      flag_z_q    <= 1'b0;
      flag_n_q    <= 1'b0;
      flag_v_q    <= 1'b0;
      rsp_valid_q <= 1'b0;
      cmd_ready_q <= 1'b1;
      op_q        <= '0;
      data_q      <= '0;
      count_q     <= '0;
      prod_q      <= '0;
      mcand_q     <= '0;
      ovf_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      flag_c_q    <= flag_c_d;
      flag_z_q    <= flag_z_d;
      flag_n_q    <= flag_n_d;
      flag_v_q    <= flag_v_d;
      rsp_valid_q <= rsp_valid_d;
      cmd_ready_q <= cmd_ready_d;
      op_q        <= op_d;
      data_q      <= data_d;
      count_q     <= count_d;
      prod_q      <= prod_d;
      mcand_q     <= mcand_d;
      ovf_q       <= ovf_d;
    end
  end

  assign cmd_ready = cmd_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign acc       = acc_q;
  assign flag_c    = flag_c_q;
  assign flag_z    = flag_z_q;
  assign flag_n    = flag_n_q;
  assign flag_v    = flag_v_q;

endmodule
